mmc_spi_xfer: RTL and testbench
===============================

// Module: mmc_spi_xfer
// PURPOSE
//  SPI byte engine beneath mmc_block_dev: shifts one byte out on mmc_di and one in from mmc_do per request.
//  Drives the card pins mmc_cs/mmc_sclk/mmc_di (SPI mode 0, MSB first); mmc_block_dev sequences commands/data through it.
//  Slow clock for card init, fast clock for sector transfers; chip select is a level request serviced between bytes.
// PARAMETERS
//  SLOW_DIV  64  clk cycles per sclk half-period in slow mode (init, <=400 kHz)
//  FAST_DIV  2   clk cycles per sclk half-period in fast mode; both must be >=1
// PORTS
//  clk       in   1  system clock, all state on posedge
//  reset_n   in   1  asynchronous, active-low reset
//  start     in   1  request one byte transfer; accepted only when busy=0
//  tx_byte   in   8  byte to send, captured on accepted start
//  slow      in   1  1=SLOW_DIV, 0=FAST_DIV; captured on accepted start
//  cs_req    in   1  1=select card (mmc_cs low)
//  busy      out  1  transfer in progress
//  done      out  1  one-cycle pulse, rx_byte valid
//  rx_byte   out  8  last received byte, held until next done
//  mmc_cs    out  1  card chip select, active low
//  mmc_sclk  out  1  SPI clock, idles low
//  mmc_di    out  1  data to card (MOSI), idles high
//  mmc_do    in   1  data from card (MISO)
// BEHAVIOUR
//  Reset (async, reset_n=0): busy=0, done=0, rx_byte=8'h00, mmc_cs=1, mmc_sclk=0, mmc_di=1, state=IDLE, bit count=0.
//  Reset mid-transfer aborts at once; no done pulse; pins return to idle values.
//  All outputs registered. Divider D = SLOW_DIV or FAST_DIV, latched at start; slow changes while busy are ignored.
//  States: IDLE -> LOW -> HIGH -> (LOW | DONE) -> IDLE.
//   IDLE: busy=0, sclk=0, di=1. start=1 at edge T0 -> latch tx_byte/D, busy=1, di=tx_byte[7], bit=7, go LOW.
//   LOW: sclk=0 for D cycles, then sclk=1, go HIGH; mmc_do sampled on that same edge into shift reg LSB.
//   HIGH: sclk=1 for D cycles, then sclk=0; if bit!=0: bit-=1, di=next bit, go LOW; else go DONE.
//   DONE (one cycle): done=1, rx_byte=shift reg, busy=0, di=1; go IDLE.
//  Timing: sclk rising edges at T0+(2k+1)*D, k=0..7; falling at T0+(2k+2)*D; done high in cycle starting T0+16*D.
//  Total start->done latency 16*D clk cycles; FAST_DIV=2 gives 32 cycles per byte.
//  Back-to-back: start may be asserted during the DONE cycle; it is accepted (busy=0) and the next byte starts with no gap.
//  start while busy=1 is ignored (no queueing); tx_byte may change freely after acceptance.
//  mmc_cs = ~cs_req, registered, updated only when state=IDLE or DONE; a cs_req change mid-byte takes effect in DONE cycle.
//  mmc_di changes only while sclk=0 (setup >= D cycles before rising edge); received bits assemble MSB first.
//  D=1 legal: each sclk phase lasts one clk cycle.
// TESTING
//  FAST_DIV=2, cs_req=1, start tx=8'h40, card model drives 8'hA5 -> di sampled 0,1,0,0,0,0,0,0 on rising edges; rx_byte=8'hA5, done at T0+32, one cycle.
//  slow=1 (SLOW_DIV=64), tx=8'hFF -> 8 rising edges 128 clk apart, first at T0+64; done at T0+1024; slow deasserted mid-byte has no effect.
//  start pulsed again at T0+10 while busy -> ignored; exactly one done; second start in DONE cycle -> next byte begins, done at T0+64.
//  cs_req 1->0 at T0+5 mid-byte -> mmc_cs stays 0 until DONE cycle, then 1; idle toggle of cs_req -> mmc_cs follows one cycle later.
//  reset_n low at T0+20 -> busy=0, mmc_sclk=0, mmc_di=1, mmc_cs=1, rx_byte=00 immediately (async); no done; after release, a new start completes normally.

Source files
------------

// File: rtl/mmc_spi_xfer.sv
// SPI mode-0 byte engine for the MMC card interface.
// One request shifts tx_byte out on mmc_di (MSB first) while assembling the
// byte returned on mmc_do. The sclk half-period is chosen per byte (slow for
// card init, fast for sector traffic). Chip select follows cs_req, but only
// at byte boundaries.
//
// Handshake: start is a request that is accepted on any rising clk edge
// where busy=0 (IDLE or the single DONE cycle); tx_byte and slow are
// captured on that edge and may change freely afterwards. Requests made
// while busy=1 are dropped. done pulses for exactly one cycle with rx_byte
// valid, and rx_byte holds until the next done.
module mmc_spi_xfer #(
  parameter int SLOW_DIV = 64,
  parameter int FAST_DIV = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       slow,
  input  logic       cs_req,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       mmc_cs,
  output logic       mmc_sclk,
  output logic       mmc_di,
  input  logic       mmc_do,
  output logic [1:0] state_dbg
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW      = $clog2(MAX_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [7:0]    rx_q, rx_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          di_q, di_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] div_q, div_d;
  // One register serves both directions: its MSB is the next bit to send,
  // and card bits enter at the LSB on each rising sclk edge.
  logic [7:0]    sr_q, sr_d;
  logic          phase_end;

  assign phase_end = (cnt_q == div_q - CW'(1));

  // Next-state and registered-output computation for the bit sequencer
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rx_d    = rx_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    di_d    = di_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sclk_d  = 1'b0;
        di_d    = 1'b1;
        cnt_d   = '0;
        if (start) begin
          state_d = S_LOW;
          busy_d  = 1'b1;
          sr_d    = tx_byte;
          di_d    = tx_byte[7];
          bit_d   = 3'd7;
          div_d   = slow ? CW'(SLOW_DIV) : CW'(FAST_DIV);
        end
      end
      S_LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          sr_d    = {sr_q[6:0], mmc_do};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            di_d    = sr_q[7];
            state_d = S_LOW;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rx_d    = sr_q;
            busy_d  = 1'b0;
            di_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Chip select only moves between bytes; updating on entry to DONE makes a
    // mid-byte cs_req change visible in the DONE cycle itself, and updating
    // in IDLE/DONE lets a cs_req raised together with start select the card
    // for that same byte.
    if (state_q == S_IDLE || state_q == S_DONE || state_d == S_DONE) begin
      cs_d = ~cs_req;
    end
  end

  // State and output registers, asynchronously returned to idle pin levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= 8'h00;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      di_q    <= 1'b1;
      bit_q   <= 3'd0;
      cnt_q   <= '0;
      div_q   <= CW'(FAST_DIV);
      sr_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      di_q    <= di_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sr_q    <= sr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rx_byte   = rx_q;
  assign mmc_cs    = cs_q;
  assign mmc_sclk  = sclk_q;
  assign mmc_di    = di_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mmc_spi_xfer.sv
// Bench for mmc_spi_xfer: a card model answers each byte, and a reference
// derived from the SPI timing rules predicts edge times, sampled MOSI bits,
// latency and the received byte.
module tb_mmc_spi_xfer;

  localparam int SD = 64;
  localparam int FD = 2;
  localparam int O_IGN   = 1;
  localparam int O_FLIP  = 2;
  localparam int O_CS    = 4;
  localparam int O_CHAIN = 8;
  localparam int O_RST   = 16;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       start;
  logic [7:0] tx_byte;
  logic       slow;
  logic       cs_req;
  logic       busy;
  logic       done;
  logic [7:0] rx_byte;
  logic       mmc_cs;
  logic       mmc_sclk;
  logic       mmc_di;
  logic       mmc_do;
  logic [1:0] state_dbg;

  mmc_spi_xfer #(.SLOW_DIV(SD), .FAST_DIV(FD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .tx_byte   (tx_byte),
    .slow      (slow),
    .cs_req    (cs_req),
    .busy      (busy),
    .done      (done),
    .rx_byte   (rx_byte),
    .mmc_cs    (mmc_cs),
    .mmc_sclk  (mmc_sclk),
    .mmc_di    (mmc_di),
    .mmc_do    (mmc_do),
    .state_dbg (state_dbg)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // driver: one byte transfer with optional disturbances, checked against
  // the timing rules (rising edges at (2k+1)*D, done at 16*D after accept)
  task automatic xfer(input logic [7:0] tx, input logic [7:0] card, input logic slw,
                      input int opts, input logic pre,
                      input logic [7:0] nxt_tx, input logic [7:0] nxt_card);
    int d, rises, cidx, viol, cs_bad, done_n, err, extra;
    int rise_n[16];
    logic rise_di[16];
    logic prev_sclk, prev_di, cs_at_done;
    logic [7:0] rx_seen, exp;
    d = slw ? SD : FD;
    rises = 0; cidx = 0; viol = 0; cs_bad = 0; done_n = 0; err = 0; extra = 0;
    rx_seen = 8'h00; cs_at_done = 1'b0;
    if (!pre) begin
      @(negedge clk);
      start = 1'b1; tx_byte = tx; slow = slw; mmc_do = card[7];
      exp_q.push_back(card);
    end
    @(posedge clk); #1;
    start = 1'b0;
    tx_byte = 8'($urandom);
    check("t0_busy", 32'(busy), 32'd1);
    check("t0_di", 32'(mmc_di), 32'(tx[7]));
    prev_sclk = mmc_sclk;
    prev_di = mmc_di;
    for (int n = 1; n <= 16 * d + 4; n++) begin
      @(posedge clk); #1;
      if (mmc_sclk && !prev_sclk) begin
        if (rises < 16) begin
          rise_n[rises] = n;
          rise_di[rises] = mmc_di;
        end
        rises++;
      end
      if (!mmc_sclk && prev_sclk) begin
        cidx++;
        if (cidx < 8) mmc_do = card[7 - cidx];
      end
      if (mmc_di !== prev_di && mmc_sclk) viol++;
      prev_sclk = mmc_sclk;
      prev_di = mmc_di;
      if (done) begin
        done_n = n;
        rx_seen = rx_byte;
        cs_at_done = mmc_cs;
        if ((opts & O_CHAIN) != 0) begin
          start = 1'b1; tx_byte = nxt_tx; slow = 1'b0; mmc_do = nxt_card[7];
          exp_q.push_back(nxt_card);
        end
        break;
      end
      if ((opts & O_CS) != 0 && n > 5 && mmc_cs !== 1'b0) cs_bad++;
      if ((opts & O_RST) != 0 && n == 20) begin
        reset_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pins", 32'({mmc_cs, mmc_sclk, mmc_di}), 32'b101);
        check("rst_rx", 32'(rx_byte), 32'h00);
        check("rst_done", 32'(done), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) begin
          @(posedge clk); #1;
          if (done) extra++;
        end
        check("rst_no_done", 32'(extra), 32'd0);
        slow = 1'b0;
        return;
      end
      if ((opts & O_FLIP) != 0 && n == 3) slow = ~slow;
      if ((opts & O_CS) != 0 && n == 5) cs_req = 1'b0;
      if ((opts & O_IGN) != 0 && n == 10) begin start = 1'b1; tx_byte = 8'($urandom); end
      if ((opts & O_IGN) != 0 && n == 11) start = 1'b0;
    end
    exp = exp_q.pop_front();
    check("latency", 32'(done_n), 32'(16 * d));
    check("rises", 32'(rises), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k >= rises || rise_n[k] != (2 * k + 1) * d || rise_di[k] !== tx[7 - k]) err++;
    end
    check("edges", 32'(err), 32'd0);
    check("rx", 32'(rx_seen), 32'(exp));
    check("di_setup", 32'(viol), 32'd0);
    if ((opts & O_CS) != 0) begin
      check("cs_mid", 32'(cs_bad), 32'd0);
      check("cs_done", 32'(cs_at_done), 32'd1);
      cs_req = 1'b1;
    end
    if ((opts & O_CHAIN) == 0) begin
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_pins", 32'({mmc_sclk, mmc_di}), 32'b01);
      repeat (3) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      if ((opts & O_IGN) != 0) check("one_done", 32'(extra), 32'd0);
    end
    slow = 1'b0;
  endtask

  logic       chained;
  logic [7:0] c_tx, c_card, n_tx, n_card;
  int         opts;

  initial begin
    reset_n = 1'b1; start = 1'b0; tx_byte = 8'h00; slow = 1'b0;
    cs_req = 1'b1; mmc_do = 1'b1;
    #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rx", 32'(rx_byte), 32'h00);
    check("reset_pins", 32'({mmc_cs, mmc_sclk, mmc_di}), 32'b101);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("cs_sel", 32'(mmc_cs), 32'd0);

    // idle toggle of cs_req: mmc_cs follows on the next edge
    @(negedge clk);
    cs_req = 1'b0;
    check("cs_hold", 32'(mmc_cs), 32'd0);
    @(posedge clk); #1;
    check("cs_idle_off", 32'(mmc_cs), 32'd1);
    @(negedge clk);
    cs_req = 1'b1;
    @(posedge clk); #1;
    check("cs_idle_on", 32'(mmc_cs), 32'd0);

    // reference byte: 0x40 out, 0xA5 back
    xfer(8'h40, 8'hA5, 1'b0, 0, 1'b0, 8'h00, 8'h00);

    // ignored start while busy, then back-to-back byte from the DONE cycle
    n_tx = 8'($urandom); n_card = 8'($urandom);
    xfer(8'($urandom), 8'($urandom), 1'b0, O_IGN | O_CHAIN, 1'b0, n_tx, n_card);
    xfer(n_tx, n_card, 1'b0, 0, 1'b1, 8'h00, 8'h00);

    // cs_req dropped mid-byte
    xfer(8'($urandom), 8'($urandom), 1'b0, O_CS, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    check("cs_restore", 32'(mmc_cs), 32'd0);

    // slow byte with slow deasserted mid-byte
    xfer(8'hFF, 8'($urandom), 1'b1, O_FLIP, 1'b0, 8'h00, 8'h00);

    // randomized fast bytes, some chained back-to-back
    chained = 1'b0;
    c_tx = 8'($urandom); c_card = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      opts = 0;
      if (i < 9 && $urandom_range(0, 1) == 1) opts = opts | O_CHAIN;
      if ($urandom_range(0, 3) == 0) opts = opts | O_FLIP;
      n_tx = 8'($urandom); n_card = 8'($urandom);
      xfer(c_tx, c_card, 1'b0, opts, chained, n_tx, n_card);
      chained = ((opts & O_CHAIN) != 0);
      if (chained) begin
        c_tx = n_tx; c_card = n_card;
      end else begin
        c_tx = 8'($urandom); c_card = 8'($urandom);
      end
    end

    // reset mid-byte, then a normal byte afterwards
    xfer(8'($urandom), 8'($urandom), 1'b0, O_RST, 1'b0, 8'h00, 8'h00);
    xfer(8'($urandom), 8'($urandom), 1'b0, 0, 1'b0, 8'h00, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
